irq_gateway: RTL
================

# irq_gateway

External interrupt gateway upstream of the core-local interrupt controller. It synchronises up to `NumSrc` asynchronous interrupt lines and detects edge or level requests per source. It holds each captured request until the controller accepts it on a valid/ready pend port, then blocks the source until the controller reports the interrupt as taken. Its pend port drives the controller's entry pend-bit write path; its acknowledge port is driven from the controller's take indication (`interrupt_out` qualified with `int_id`).

## Interface
Parameters:
- `NumSrc`, 8: number of external interrupt lines, 2..32.
- `SyncStages`, 2: flip-flop synchroniser depth per line, minimum 2.
- `IdWidth`, `$clog2(NumSrc)`: width of source identifiers.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  NumSrc  raw external interrupt lines, asynchronous to `clk`.
- `irq_enable`  in  NumSrc  per-source enable mask.
- `irq_edge`  in  NumSrc  per-source mode: 1 = rising edge, 0 = active-high level.
- `pend_valid`  out  1  registered; a request is offered to the controller.
- `pend_id`  out  IdWidth  registered; source index of the offered request.
- `pend_ready`  in  1  controller accepts the offered request this cycle.
- `ack_valid`  in  1  controller has taken an interrupt this cycle.
- `ack_id`  in  IdWidth  index of the taken interrupt.
- `inflight`  out  NumSrc  registered; per-source INFLIGHT state.
- `overrun_count`  out  8  registered; saturating count of lost edges.

## Operation
- Each line passes through a `SyncStages`-deep synchroniser, then a 1-cycle history register; `rise[i] = sync[i] & ~hist[i]`.
- Per-source state machine:
  - **IDLE**
    - Goes to PENDING when `irq_enable[i]` and (`irq_edge[i] ? rise[i] : sync[i]`).
  - **PENDING**
    - Goes to INFLIGHT when this source is transferred on the pend port.
    - Goes to IDLE when `irq_enable[i]` is 0, unless it is held in the output slot.
  - **INFLIGHT**
    - On `ack_valid && ack_id == i`:
      - In edge mode, goes to PENDING if the re-pend flag is set, otherwise to IDLE.
      - In level mode, goes to PENDING if `sync[i]` and enabled, otherwise to IDLE.
- Re-pend flag (edge mode only):
  - Set by `rise[i]` while the source is PENDING or INFLIGHT.
  - Cleared when the flag is consumed on ack, or when the source is disabled.
  - A `rise[i]` while the flag is already set increments `overrun_count`, which saturates at 255.
- Output slot:
  - A single register pair `pend_valid`/`pend_id`.
  - It loads when empty or when a transfer completes this cycle.
  - The loaded source is the round-robin winner among PENDING sources not already in the slot.
  - The search starts at the index after the last transferred source and wraps at `NumSrc-1` -> 0.
- Valid/ready rules:
  - A transfer occurs when `pend_valid && pend_ready` at a clock edge.
  - While `pend_valid && !pend_ready`, `pend_id` is held stable.
  - `pend_valid` never retracts without a transfer, even if the source is disabled meanwhile.
- Acknowledge handling:
  - An ack for a source not in INFLIGHT is ignored.
  - `ack_id >= NumSrc` is ignored.
- Simultaneous events:
  - A transfer and an ack for the same id in one cycle: the ack sees PENDING and is ignored.
  - A transfer of one id and an ack of another in one cycle are both applied.
  - Rise and disable in the same cycle: disable wins.

## Timing
- Reset values:
  - All states IDLE; re-pend flags 0.
  - Synchroniser and history registers 0.
  - Round-robin pointer 0.
  - `pend_valid` 0, `pend_id` 0, `inflight` 0, `overrun_count` 0.
- Latency with `SyncStages`=2:
  - A line rising before edge 1 gives PENDING after edge 3.
  - `pend_valid` is 1 after edge 4, provided the slot is free.
  - General case: `SyncStages+2` edges.
- Throughput: one transfer per cycle with `pend_ready` held high.
  - The slot reloads on the same edge as a transfer.
  - No bubble when another source is PENDING.
- `inflight[i]` rises on the edge of the transfer and falls on the edge of the matching ack.
- Reset asserted mid-operation:
  - Takes effect immediately and asynchronously.
  - All state clears; in-progress requests are discarded, not replayed.
  - Deassertion is synchronous to `clk` and handled at integration.

## Test plan
- **Single edge request:** `irq_edge[3]=1`, enabled, pulse `irq_in[3]` for 3 cycles, `pend_ready=1`.
  - `pend_valid=1`, `pend_id=3` exactly 4 edges later, for one cycle.
  - `inflight[3]=1` until `ack_valid`, `ack_id=3`, then 0.
- **Backpressure:** sources 1 and 5 pending, `pend_ready=0` for 10 cycles.
  - `pend_id` stays 1, `pend_valid` stays 1.
  - On release, transfer 1 then 5 on consecutive edges.
- **Round-robin fairness:** sources 0, 2 and 6 level-held, with an ack after each transfer.
  - Transfer order is 0, 2, 6, 0, 2, 6.
- **Level re-arm:** level source 4 held high through the ack.
  - PENDING again on the ack edge; `pend_valid` with id 4 on the next edge.
  - With the line low at the ack, the source returns to IDLE and `pend_valid` stays 0.
- **Edge overrun:** edge source 2 INFLIGHT, then 3 rising edges before the ack.
  - Re-pend flag set; `overrun_count` = 2.
  - After the ack, exactly one new transfer with id 2.
- **Disable and reset mid-operation:**
  - Disable a PENDING source 7 that is not in the slot: it is never offered.
  - Assert `reset` low with slot valid and 2 sources INFLIGHT: all outputs are 0 immediately.

Source files
------------

// File: rtl/irq_gateway_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_gateway_if
//  Description : Pend / acknowledge channel between the external interrupt
//                gateway and the core-local interrupt controller.
//                  pend_valid / pend_id  : request offered by the gateway
//                  pend_ready            : controller accepts the request
//                  ack_valid / ack_id    : controller has taken interrupt id
//                The master modport is the gateway side and the slave modport
//                is the controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_gateway_if #(
    parameter int NumSrc  = 8,
    parameter int IdWidth = $clog2(NumSrc)
) ();
    logic               pend_valid;
    logic [IdWidth-1:0] pend_id;
    logic               pend_ready;
    logic               ack_valid;
    logic [IdWidth-1:0] ack_id;

    modport master (
        output pend_valid,
        output pend_id,
        input  pend_ready,
        input  ack_valid,
        input  ack_id
    );

    modport slave (
        input  pend_valid,
        input  pend_id,
        output pend_ready,
        output ack_valid,
        output ack_id
    );
endinterface
`default_nettype wire

// File: rtl/irq_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : irq_gateway
//  Description : External interrupt gateway. Synchronises NumSrc asynchronous
//                interrupt lines, detects rising-edge or active-high level
//                requests per source, offers one request at a time to the
//                interrupt controller through a registered valid/ready slot
//                (round-robin between pending sources) and blocks each source
//                until the controller acknowledges it as taken.
//  Ports       : clk            core clock
//                reset          asynchronous, active-low reset
//                irq_in         raw interrupt lines (asynchronous)
//                irq_enable     per-source enable mask
//                irq_edge       per-source mode, 1 = rising edge, 0 = level
//                pend_if        pend (valid/id/ready) and ack (valid/id)
//                inflight       per-source INFLIGHT state (registered)
//                overrun_count  saturating count of lost edges (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module irq_gateway #(
    parameter int NumSrc     = 8,
    parameter int SyncStages = 2,
    parameter int IdWidth    = $clog2(NumSrc)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [NumSrc-1:0] irq_in,
    input  wire logic [NumSrc-1:0] irq_enable,
    input  wire logic [NumSrc-1:0] irq_edge,
    irq_gateway_if.master          pend_if,
    output logic      [NumSrc-1:0] inflight,
    output logic      [7:0]        overrun_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_e;

    // Synchroniser chain, edge history and per-source state
    logic [NumSrc-1:0]  sync_q [SyncStages];
    logic [NumSrc-1:0]  hist_q;
    logic [NumSrc-1:0]  sync_s;
    logic [NumSrc-1:0]  rise;

    state_e             state_q [NumSrc];
    state_e             state_d [NumSrc];
    logic [NumSrc-1:0]  repend_q, repend_d;
    logic [NumSrc-1:0]  inflight_q, inflight_d;
    logic [7:0]         overrun_q, overrun_d;

    // Output slot and round-robin pointer (index to start the next search at)
    logic               pend_valid_q, pend_valid_d;
    logic [IdWidth-1:0] pend_id_q, pend_id_d;
    logic [IdWidth-1:0] ptr_q, ptr_d;

    logic               xfer;
    logic [NumSrc-1:0]  in_slot, xfer_hit, ack_hit, cand;
    logic [IdWidth-1:0] start;
    logic [IdWidth-1:0] win;
    logic               found;
    logic [8:0]         ovr_sum;
    int                 ovr_inc;
    int                 idx;

    assign sync_s = sync_q[SyncStages-1];
    assign rise   = sync_s & ~hist_q;

    always_comb begin
        xfer    = pend_valid_q && pend_if.pend_ready;
        ovr_inc = 0;
        idx     = 0;

        for (int i = 0; i < NumSrc; i++) begin
            in_slot[i]  = pend_valid_q && (pend_id_q == IdWidth'(i));
            xfer_hit[i] = xfer && (pend_id_q == IdWidth'(i));
            // ack_id values >= NumSrc never match any i and are dropped here
            ack_hit[i]  = pend_if.ack_valid && (pend_if.ack_id == IdWidth'(i));
            cand[i]     = (state_q[i] == ST_PENDING) && irq_enable[i] && !in_slot[i];

            state_d[i]  = state_q[i];
            repend_d[i] = repend_q[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (irq_enable[i] && (irq_edge[i] ? rise[i] : sync_s[i]))
                        state_d[i] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (xfer_hit[i])
                        state_d[i] = ST_INFLIGHT;
                    else if (!irq_enable[i] && !in_slot[i])
                        state_d[i] = ST_IDLE;
                end
                ST_INFLIGHT: begin
                    if (ack_hit[i]) begin
                        if (irq_edge[i])
                            state_d[i] = (repend_q[i] && irq_enable[i]) ? ST_PENDING : ST_IDLE;
                        else
                            state_d[i] = (sync_s[i] && irq_enable[i]) ? ST_PENDING : ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // Re-pend flag remembers one extra edge seen while the source is
            // busy; a further edge on top of it is counted as lost.
            if (!irq_enable[i]) begin
                repend_d[i] = 1'b0;
            end else if (irq_edge[i] && (state_q[i] != ST_IDLE)) begin
                if ((state_q[i] == ST_INFLIGHT) && ack_hit[i]) begin
                    // Flag is consumed; an edge arriving in the same cycle
                    // is kept only if the source re-enters PENDING.
                    repend_d[i] = rise[i] && repend_q[i];
                end else if (rise[i]) begin
                    if (repend_q[i])
                        ovr_inc = ovr_inc + 1;
                    repend_d[i] = 1'b1;
                end
            end

            inflight_d[i] = (state_d[i] == ST_INFLIGHT);
        end

        ovr_sum   = {1'b0, overrun_q} + 9'(ovr_inc);
        overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

        // Round-robin search begins just after the most recently transferred
        // source, including a transfer completing on this very edge.
        if (xfer)
            start = (pend_id_q == IdWidth'(NumSrc-1)) ? '0 : pend_id_q + 1'b1;
        else
            start = ptr_q;

        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NumSrc; k++) begin
            idx = int'(start) + k;
            if (idx >= NumSrc)
                idx = idx - NumSrc;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IdWidth'(idx);
            end
        end

        ptr_d        = xfer ? start : ptr_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        if (!pend_valid_q || xfer) begin
            pend_valid_d = found;
            if (found)
                pend_id_d = win;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SyncStages; s++)
                sync_q[s] <= '0;
            hist_q <= '0;
            for (int i = 0; i < NumSrc; i++)
                state_q[i] <= ST_IDLE;
            repend_q     <= '0;
            inflight_q   <= '0;
            overrun_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            ptr_q        <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SyncStages; s++)
                sync_q[s] <= sync_q[s-1];
            hist_q <= sync_s;
            for (int i = 0; i < NumSrc; i++)
                state_q[i] <= state_d[i];
            repend_q     <= repend_d;
            inflight_q   <= inflight_d;
            overrun_q    <= overrun_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign pend_if.pend_valid = pend_valid_q;
    assign pend_if.pend_id    = pend_id_q;
    assign inflight           = inflight_q;
    assign overrun_count      = overrun_q;

endmodule
`default_nettype wire
